// File: rtl/banco_registros_sb_if.sv
// Register file bus: write port, two read ports, scoreboard
// reservation and sequential clear control.
interface banco_registros_sb_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              write_enable;
  logic [ADDR_W-1:0] write_reg;
  logic [WIDTH-1:0]  write_data;
  logic [ADDR_W-1:0] read_reg_1;
  logic [ADDR_W-1:0] read_reg_2;
  logic [WIDTH-1:0]  read_data_1;
  logic [WIDTH-1:0]  read_data_2;
  logic              reserve_en;
  logic [ADDR_W-1:0] reserve_reg;
  logic              ready_1;
  logic              ready_2;
  logic              clear_req;
  logic              clear_busy;

  modport master (
    output write_enable, write_reg, write_data,
    output read_reg_1, read_reg_2,
    output reserve_en, reserve_reg, clear_req,
    input  read_data_1, read_data_2,
    input  ready_1, ready_2, clear_busy
  );

  modport slave (
    input  write_enable, write_reg, write_data,
    input  read_reg_1, read_reg_2,
    input  reserve_en, reserve_reg, clear_req,
    output read_data_1, read_data_2,
    output ready_1, ready_2, clear_busy
  );
endinterface

// File: rtl/banco_registros_sb.sv
// Register file with write-first bypass, per-register pending
// scoreboard and a one-register-per-cycle sequential clear.
module banco_registros_sb #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic rst_n,
  banco_registros_sb_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [ADDR_W-1:0] cnt;

  logic idle;
  logic wr_ok;
  logic rsv_ok;
  logic z1, z2, byp1, byp2;

  assign idle   = (state == IDLE);
  assign wr_ok  = bus.write_enable & idle &
                  !(ZERO_REG != 0 && bus.write_reg == '0);
  assign rsv_ok = bus.reserve_en & idle &
                  !(ZERO_REG != 0 && bus.reserve_reg == '0);

  assign z1   = (ZERO_REG != 0) && (bus.read_reg_1 == '0);
  assign z2   = (ZERO_REG != 0) && (bus.read_reg_2 == '0);
  assign byp1 = wr_ok && (bus.write_reg == bus.read_reg_1);
  assign byp2 = wr_ok && (bus.write_reg == bus.read_reg_2);

  // z and byp are exclusive: wr_ok never targets r0 when hardwired
  always_comb begin
    bus.read_data_1 = mem[bus.read_reg_1];
    unique case (1'b1)
      z1:      bus.read_data_1 = '0;
      byp1:    bus.read_data_1 = bus.write_data;
      default: bus.read_data_1 = mem[bus.read_reg_1];
    endcase
  end

  always_comb begin
    bus.read_data_2 = mem[bus.read_reg_2];
    unique case (1'b1)
      z2:      bus.read_data_2 = '0;
      byp2:    bus.read_data_2 = bus.write_data;
      default: bus.read_data_2 = mem[bus.read_reg_2];
    endcase
  end

  assign bus.ready_1    = !pend[bus.read_reg_1] | byp1;
  assign bus.ready_2    = !pend[bus.read_reg_2] | byp2;
  assign bus.clear_busy = (state == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend  <= '0;
      cnt   <= '0;
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_ok) begin
            mem[bus.write_reg]  <= bus.write_data;
            pend[bus.write_reg] <= 1'b0;
          end
          // reserve after write: the newer producer wins
          if (rsv_ok) pend[bus.reserve_reg] <= 1'b1;
          if (bus.clear_req) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          mem[cnt]  <= '0;
          pend[cnt] <= 1'b0;
          cnt       <= cnt + 1'b1;
          if (cnt == ADDR_W'(DEPTH-1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_banco_registros_sb.sv
// Bench for banco_registros_sb: directed table, clear/reset
// sequences and random traffic against a behavioural model.
module tb_banco_registros_sb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  banco_registros_sb_if #(.WIDTH(32), .ADDR_W(5)) bus ();
  banco_registros_sb_if #(.WIDTH(32), .ADDR_W(5)) bus0 ();

  banco_registros_sb #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  banco_registros_sb #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        re;
    logic [4:0]  rr;
    logic        clr;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        y1;
    logic        y2;
    logic        b;
  } vec_t;

  vec_t tbl [14];

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m_mem [32];
  bit          m_pend [32];
  bit          m_busy;
  int          m_idx;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic drive(logic we, logic [4:0] wr, logic [31:0] wd,
                       logic [4:0] r1, logic [4:0] r2, logic re,
                       logic [4:0] rr, logic clr);
    bus.write_enable = we;
    bus.write_reg    = wr;
    bus.write_data   = wd;
    bus.read_reg_1   = r1;
    bus.read_reg_2   = r2;
    bus.reserve_en   = re;
    bus.reserve_reg  = rr;
    bus.clear_req    = clr;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_idx  = 0;
  endtask

  function automatic bit m_acc();
    return bus.write_enable && !m_busy && bus.write_reg != 0;
  endfunction

  function automatic logic [31:0] m_rd(logic [4:0] a);
    if (a == 0) return '0;
    if (m_acc() && bus.write_reg == a) return bus.write_data;
    return m_mem[a];
  endfunction

  function automatic logic m_rdy(logic [4:0] a);
    return !m_pend[a] || (m_acc() && bus.write_reg == a);
  endfunction

  task automatic model_check();
    chk("rd1", bus.read_data_1, m_rd(bus.read_reg_1));
    chk("rd2", bus.read_data_2, m_rd(bus.read_reg_2));
    chk("rdy1", 32'(bus.ready_1), 32'(m_rdy(bus.read_reg_1)));
    chk("rdy2", 32'(bus.ready_2), 32'(m_rdy(bus.read_reg_2)));
    chk("busy", 32'(bus.clear_busy), 32'(m_busy));
  endtask

  task automatic model_step();
    if (m_busy) begin
      m_mem[m_idx]  = '0;
      m_pend[m_idx] = 1'b0;
      m_idx++;
      if (m_idx == 32) begin
        m_busy = 1'b0;
        m_idx  = 0;
      end
    end else begin
      if (m_acc()) begin
        m_mem[bus.write_reg]  = bus.write_data;
        m_pend[bus.write_reg] = 1'b0;
      end
      if (bus.reserve_en && bus.reserve_reg != 0)
        m_pend[bus.reserve_reg] = 1'b1;
      if (bus.clear_req) begin
        m_busy = 1'b1;
        m_idx  = 0;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    logic [4:0] a;

    tbl[0]  = '{0,0,0,        5,5,0,0,0, 0,0,1,1,0};
    tbl[1]  = '{1,5,32'hDEADBEEF, 5,5,0,0,0,
                32'hDEADBEEF,32'hDEADBEEF,1,1,0};
    tbl[2]  = '{0,0,0,        5,5,0,0,0,
                32'hDEADBEEF,32'hDEADBEEF,1,1,0};
    tbl[3]  = '{1,0,32'h12345678, 0,0,0,0,0, 0,0,1,1,0};
    tbl[4]  = '{0,0,0,        0,5,0,0,0, 0,32'hDEADBEEF,1,1,0};
    tbl[5]  = '{1,7,32'hA5A5A5A5, 7,5,0,0,0,
                32'hA5A5A5A5,32'hDEADBEEF,1,1,0};
    tbl[6]  = '{0,0,0,        3,7,1,3,0, 0,32'hA5A5A5A5,1,1,0};
    tbl[7]  = '{0,0,0,        3,7,0,0,0, 0,32'hA5A5A5A5,0,1,0};
    tbl[8]  = '{1,3,32'h11,   3,7,0,0,0, 32'h11,32'hA5A5A5A5,1,1,0};
    tbl[9]  = '{0,0,0,        3,7,0,0,0, 32'h11,32'hA5A5A5A5,1,1,0};
    tbl[10] = '{1,3,32'h11,   3,7,1,3,0, 32'h11,32'hA5A5A5A5,1,1,0};
    tbl[11] = '{0,0,0,        3,7,0,0,0, 32'h11,32'hA5A5A5A5,0,1,0};
    tbl[12] = '{0,0,0,        0,7,1,0,0, 0,32'hA5A5A5A5,1,1,0};
    tbl[13] = '{0,0,0,        0,7,0,0,0, 0,32'hA5A5A5A5,1,1,0};

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    bus0.write_enable = 0; bus0.write_reg = 0; bus0.write_data = 0;
    bus0.read_reg_1 = 0; bus0.read_reg_2 = 0;
    bus0.reserve_en = 0; bus0.reserve_reg = 0; bus0.clear_req = 0;
    m_reset();

    // reset state, before any clock edge
    #2;
    chk("rst_rd1", bus.read_data_1, 0);
    chk("rst_rdy1", 32'(bus.ready_1), 1);
    chk("rst_busy", 32'(bus.clear_busy), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].we, tbl[i].wr, tbl[i].wd, tbl[i].r1,
            tbl[i].r2, tbl[i].re, tbl[i].rr, tbl[i].clr);
      @(negedge clk);
      chk($sformatf("tbl%0d_rd1", i), bus.read_data_1, tbl[i].e1);
      chk($sformatf("tbl%0d_rd2", i), bus.read_data_2, tbl[i].e2);
      chk($sformatf("tbl%0d_rdy1", i), 32'(bus.ready_1), 32'(tbl[i].y1));
      chk($sformatf("tbl%0d_rdy2", i), 32'(bus.ready_2), 32'(tbl[i].y2));
      chk($sformatf("tbl%0d_busy", i), 32'(bus.clear_busy), 32'(tbl[i].b));
      model_step();
      @(posedge clk); #1;
    end

    // r0 is an ordinary register when not hardwired
    bus0.write_enable = 1; bus0.write_reg = 0;
    bus0.write_data = 32'h12345678;
    @(negedge clk);
    chk("z0_byp", bus0.read_data_1, 32'h12345678);
    @(posedge clk); #1;
    bus0.write_enable = 0;
    @(negedge clk);
    chk("z0_rd", bus0.read_data_1, 32'h12345678);
    @(posedge clk); #1;

    // fill r1..r31, leave a couple pending, then clear
    for (int i = 1; i < 32; i++) begin
      drive(1, 5'(i), $urandom | 32'h1, 5'(i), 5'($urandom),
            0, 0, 0);
      cyc();
    end
    drive(0, 0, 0, 4, 9, 1, 4, 0); cyc();
    drive(0, 0, 0, 4, 9, 1, 9, 0); cyc();
    drive(0, 0, 0, 4, 9, 0, 0, 1); cyc();
    busy_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      drive(1'($urandom), 5'($urandom), $urandom, 5'($urandom),
            5'($urandom), 1'($urandom), 5'($urandom), k < 20);
      @(negedge clk);
      model_check();
      if (!bus.clear_busy) break;
      busy_cnt++;
      model_step();
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_step();
    @(posedge clk); #1;
    chk("clr_cycles", 32'(busy_cnt), 32);
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0);
      @(negedge clk);
      chk("clr_rd1", bus.read_data_1, 0);
      chk("clr_rd2", bus.read_data_2, 0);
      chk("clr_rdy1", 32'(bus.ready_1), 1);
      model_step();
      @(posedge clk); #1;
    end

    // write coinciding with clear_req lands, then gets cleared
    drive(1, 9, 32'hCAFEF00D, 9, 9, 0, 0, 1); cyc();
    drive(0, 0, 0, 9, 9, 0, 0, 0);
    @(negedge clk);
    chk("wclr_rd", bus.read_data_1, 32'hCAFEF00D);
    chk("wclr_busy", 32'(bus.clear_busy), 1);
    model_step();
    @(posedge clk); #1;
    for (int k = 0; k < 40 && m_busy; k++) cyc();
    cyc();

    // async reset in the middle of a clear
    drive(1, 20, 32'h00001234, 20, 3, 1, 3, 0); cyc();
    drive(0, 0, 0, 20, 3, 0, 0, 1); cyc();
    drive(0, 0, 0, 20, 3, 0, 0, 0);
    for (int k = 0; k < 9; k++) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd1", bus.read_data_1, 0);
    chk("arst_rdy2", 32'(bus.ready_2), 1);
    chk("arst_busy", 32'(bus.clear_busy), 0);
    m_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_busy", 32'(bus.clear_busy), 0);
      model_step();
      @(posedge clk); #1;
    end

    // random traffic
    for (int k = 0; k < 400; k++) begin
      a = 5'($urandom);
      drive(1'($urandom), a, $urandom,
            ($urandom % 4 == 0) ? a : 5'($urandom),
            ($urandom % 4 == 0) ? a : 5'($urandom),
            ($urandom % 3 == 0), ($urandom % 4 == 0) ? a : 5'($urandom),
            ($urandom % 60 == 0));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/banco_registros_sb.md
BANCO_REGISTROS_SB -- requirements
Module: banco_registros_sb

Interface
REQ-001 Parameter WIDTH, default 32, data width of each register.
REQ-002 Parameter ADDR_W, default 5, register address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 is hardwired to zero.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 write_enable  input  1  write request for write_reg.
REQ-007 write_reg  input  ADDR_W  write address.
REQ-008 write_data  input  WIDTH  write data.
REQ-009 read_reg_1 / read_reg_2  input  ADDR_W  read addresses, ports 1 and 2.
REQ-010 read_data_1 / read_data_2  output  WIDTH  read data, ports 1 and 2.
REQ-011 reserve_en  input  1  mark reserve_reg as pending (result in flight).
REQ-012 reserve_reg  input  ADDR_W  register to reserve.
REQ-013 ready_1 / ready_2  output  1  read_reg_x holds a non-pending value.
REQ-014 clear_req  input  1  start a sequential clear of all registers.
REQ-015 clear_busy  output  1  clear sequence in progress.

Function
REQ-016 Write accepted = write_enable & !clear_busy & !(ZERO_REG & write_reg==0); accepted write updates mem[write_reg] at the rising edge.
REQ-017 Reads shall be combinational, zero latency, both ports independent.
REQ-018 With ZERO_REG=1, a read of address 0 shall return 0 regardless of any other input.
REQ-019 Bypass: if a write is accepted this cycle and write_reg == read_reg_x, read_data_x shall equal write_data (write-first).
REQ-020 Scoreboard: one pending bit per register; reserve_en (when !clear_busy) sets pend[reserve_reg] at the next edge.
REQ-021 An accepted write clears pend[write_reg] at the next edge.
REQ-022 Same-cycle reserve and accepted write to the same register: pend ends set (new producer wins); data is still written.
REQ-023 With ZERO_REG=1, pend[0] shall never be set.
REQ-024 ready_x = !pend[read_reg_x] | (write accepted this cycle & write_reg == read_reg_x).
REQ-025 FSM states IDLE, CLEAR; IDLE -> CLEAR when clear_req=1, counter loaded with 0.
REQ-026 In CLEAR, each cycle mem[counter] <= 0 and pend[counter] <= 0, counter increments; CLEAR -> IDLE after counter == DEPTH-1 is cleared; clear takes exactly DEPTH cycles.
REQ-027 clear_busy = 1 exactly while state is CLEAR; clear_req in CLEAR is ignored; counter wraps to 0 on exit.
REQ-028 During CLEAR, write_enable and reserve_en are ignored, bypass is disabled, reads return current array contents.
REQ-029 clear_req in IDLE with simultaneous write_enable: the write is accepted (clear_busy still 0) and then overwritten by the clear.

Reset
REQ-030 rst_n=0 shall immediately, independent of clk, zero all registers, all pending bits and the counter, and force state IDLE.
REQ-031 During and after reset until the first write: read_data_x = 0, ready_x = 1, clear_busy = 0.
REQ-032 rst_n asserted mid-CLEAR aborts the sequence; state IDLE after release, no resume.

Verification
REQ-033 Write 0xDEADBEEF to r5, next cycle read r5 on both ports -> read_data_1 = read_data_2 = 0xDEADBEEF, ready = 1.
REQ-034 write_enable to r0 with 0x12345678, ZERO_REG=1 -> read r0 = 0; with ZERO_REG=0 -> read r0 = 0x12345678.
REQ-035 Same cycle write r7=0xA5A5A5A5 and read_reg_1=7 -> read_data_1 = 0xA5A5A5A5 before the edge.
REQ-036 reserve r3; next cycle ready_1=0 for r3; write r3=0x11 -> ready_1=1 same cycle; same-cycle reserve+write r3 -> ready stays 0 next cycle, data 0x11.
REQ-037 Fill r1..r31 nonzero, pulse clear_req -> clear_busy high exactly 32 cycles, writes ignored meanwhile, afterwards all reads 0 and ready=1.
REQ-038 Assert rst_n=0 between clock edges in cycle 10 of CLEAR -> outputs zero and clear_busy=0 immediately, no clock required.
